// File: rtl/p_logic_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p_logic_acc_pkg : op codes, FSM states and op decode helpers          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package p_logic_acc_pkg;

  localparam logic [2:0] c_op_and  = 3'b000;
  localparam logic [2:0] c_op_or   = 3'b001;
  localparam logic [2:0] c_op_xor  = 3'b010;
  localparam logic [2:0] c_op_nand = 3'b011;
  localparam logic [2:0] c_op_nor  = 3'b100;
  localparam logic [2:0] c_op_xnor = 3'b101;
  localparam logic [2:0] c_op_pass = 3'b110;
  localparam logic [2:0] c_op_rsvd = 3'b111;

  typedef enum logic [1:0] {
    BASE_AND  = 2'd0,
    BASE_OR   = 2'd1,
    BASE_XOR  = 2'd2,
    BASE_PASS = 2'd3
  } base_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic base_e base_of(input logic [2:0] op);
    case (op)
      c_op_and,  c_op_nand: base_of = BASE_AND;
      c_op_or,   c_op_nor:  base_of = BASE_OR;
      c_op_xor,  c_op_xnor: base_of = BASE_XOR;
      default:              base_of = BASE_PASS;
    endcase
  endfunction

  function automatic logic inv_of(input logic [2:0] op);
    inv_of = (op == c_op_nand) || (op == c_op_nor) || (op == c_op_xnor);
  endfunction

endpackage
`default_nettype wire

// File: rtl/p_logic_acc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p_logic_acc_if : operand and result valid/ready streams               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface p_logic_acc_if #(
  parameter int BUS_WIDTH = 4,
  parameter int CNT_W     = 2
) ();

  logic [2:0]           op;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in_bus;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [BUS_WIDTH-1:0] out_bus;
  logic [CNT_W-1:0]     out_count;

  modport master (
    output op, in_valid, in_bus, in_last, out_ready,
    input  in_ready, out_valid, out_bus, out_count
  );

  modport slave (
    input  op, in_valid, in_bus, in_last, out_ready,
    output in_ready, out_valid, out_bus, out_count
  );

endinterface
`default_nettype wire

// File: rtl/p_logic_acc_op.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p_logic_op : combinational two-input step with optional final invert  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module p_logic_op
  import p_logic_acc_pkg::*;
#(
  parameter int BUS_WIDTH = 4
) (
  input  base_e                i_base,
  input  logic                 i_inv,
  input  logic [BUS_WIDTH-1:0] i_a,
  input  logic [BUS_WIDTH-1:0] i_b,
  output logic [BUS_WIDTH-1:0] o_y
);

  logic [BUS_WIDTH-1:0] w_raw;

  always_comb begin
    w_raw = i_a;
    case (i_base)
      BASE_AND:  w_raw = i_a & i_b;
      BASE_OR:   w_raw = i_a | i_b;
      BASE_XOR:  w_raw = i_a ^ i_b;
      default:   w_raw = i_a;
    endcase
  end

  assign o_y = i_inv ? ~w_raw : w_raw;

endmodule
`default_nettype wire

// File: rtl/p_logic_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p_logic_acc : folds up to NB_INS operands per group into one result   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module p_logic_acc
  import p_logic_acc_pkg::*;
#(
  parameter int BUS_WIDTH = 4,
  parameter int NB_INS    = 3,
  parameter int CNT_W     = $clog2(NB_INS + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  p_logic_acc_if.slave bus
);

  localparam logic [CNT_W-1:0] c_nb_ins = CNT_W'(NB_INS);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  state_e               r_state, w_state_nxt;
  logic [BUS_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [2:0]           r_op;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BUS_WIDTH-1:0] r_out_bus;
  logic [CNT_W-1:0]     r_out_count;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_close;
  logic [2:0]           w_op_cur;
  logic [BUS_WIDTH-1:0] w_fold;
  logic [BUS_WIDTH-1:0] w_result;

  assign w_in_ready = (r_state != ST_DONE);
  assign w_accept   = bus.in_valid && w_in_ready;
  // The op of a group is taken live on its first beat, from the latch afterwards.
  assign w_op_cur   = (r_state == ST_IDLE) ? bus.op : r_op;
  assign w_close    = w_accept && (bus.in_last || (w_cnt_nxt == c_nb_ins));

  p_logic_op #(.BUS_WIDTH(BUS_WIDTH)) u_fold (
    .i_base (base_of(r_op)),
    .i_inv  (1'b0),
    .i_a    (r_acc),
    .i_b    (bus.in_bus),
    .o_y    (w_fold)
  );

  p_logic_op #(.BUS_WIDTH(BUS_WIDTH)) u_final (
    .i_base (BASE_PASS),
    .i_inv  (inv_of(w_op_cur)),
    .i_a    (w_acc_nxt),
    .i_b    (w_acc_nxt),
    .o_y    (w_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_acc_nxt = bus.in_bus;
        w_cnt_nxt = c_one;
        if (w_accept) w_state_nxt = w_close ? ST_DONE : ST_ACC;
      end
      ST_ACC: begin
        w_acc_nxt = w_fold;
        w_cnt_nxt = r_cnt + c_one;
        if (w_close) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_out_bus   <= '0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        if (r_state == ST_IDLE) r_op <= bus.op;
      end
      if (w_close) begin
        r_out_bus   <= w_result;
        r_out_count <= w_cnt_nxt;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_bus   = r_out_bus;
  assign bus.out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_p_logic_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_p_logic_acc : vector table, directed corners and random groups     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_p_logic_acc;

  localparam int BW = 4;
  localparam int NB = 3;
  localparam int CW = 2;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  n;
    logic [11:0] d;
    logic [3:0]  exp_bus;
    logic [1:0]  exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  p_logic_acc_if #(.BUS_WIDTH(BW), .CNT_W(CW)) u_if ();

  p_logic_acc #(.BUS_WIDTH(BW), .NB_INS(NB), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result from the operation definitions.
  function automatic logic [3:0] model(input logic [2:0] op, input int n, input logic [11:0] d);
    logic [3:0] r;
    logic [3:0] b;
    r = d[3:0];
    for (int i = 1; i < n; i++) begin
      b = d[i*4 +: 4];
      if (op == 3'd0 || op == 3'd3) r = r & b;
      else if (op == 3'd1 || op == 3'd4) r = r | b;
      else if (op == 3'd2 || op == 3'd5) r = r ^ b;
    end
    if (op == 3'd3 || op == 3'd4 || op == 3'd5) r = ~r;
    return r;
  endfunction

  task automatic drive_beat(input logic [2:0] op, input logic [3:0] d, input logic last);
    int k;
    u_if.in_valid = 1'b1;
    u_if.op       = op;
    u_if.in_bus   = d;
    u_if.in_last  = last;
    k = 0;
    while (!u_if.in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!u_if.in_ready) check("accept_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_group(input logic [2:0] op, input int n, input logic [11:0] d, input logic last_final);
    for (int i = 0; i < n; i++) begin
      drive_beat((i == 0) ? op : 3'($urandom_range(0, 7)), d[i*4 +: 4],
                 (i == n - 1) ? last_final : 1'b0);
    end
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [3:0] eb, input logic [1:0] ec, input int delay);
    int k;
    k = 0;
    while (!u_if.out_valid && k < 20) begin
      tick();
      k++;
    end
    check({name, "_valid"}, 32'(u_if.out_valid), 32'd1);
    check({name, "_bus"}, 32'(u_if.out_bus), 32'(eb));
    check({name, "_cnt"}, 32'(u_if.out_count), 32'(ec));
    for (int i = 0; i < delay; i++) begin
      tick();
      check({name, "_hold"}, 32'(u_if.out_bus), 32'(eb));
    end
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    logic [2:0]  rop;
    int          rn;
    logic [11:0] rd;
    logic        rlast;

    u_if.op = '0; u_if.in_valid = 1'b0; u_if.in_bus = '0;
    u_if.in_last = 1'b0; u_if.out_ready = 1'b0;

    tbl[0] = '{3'b100, 2'd3, {4'b1011, 4'b1011, 4'b1001}, 4'b0100, 2'd3};
    tbl[1] = '{3'b000, 2'd2, {4'b0000, 4'b1010, 4'b1111}, 4'b1010, 2'd2};
    tbl[2] = '{3'b010, 2'd3, {4'b0111, 4'b0011, 4'b0001}, 4'b0101, 2'd3};
    tbl[3] = '{3'b110, 2'd1, {4'b0000, 4'b0000, 4'b0110}, 4'b0110, 2'd1};
    tbl[4] = '{3'b111, 2'd1, {4'b0000, 4'b0000, 4'b0110}, 4'b0110, 2'd1};
    tbl[5] = '{3'b011, 2'd2, {4'b0000, 4'b1010, 4'b1100}, 4'b0111, 2'd2};
    tbl[6] = '{3'b101, 2'd3, {4'b0001, 4'b0110, 4'b1010}, 4'b0010, 2'd3};
    tbl[7] = '{3'b110, 2'd3, {4'b0000, 4'b1111, 4'b0011}, 4'b0011, 2'd3};
    tbl[8] = '{3'b001, 2'd1, {4'b0000, 4'b0000, 4'b0101}, 4'b0101, 2'd1};

    #3;
    check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    check("rst_out_bus", 32'(u_if.out_bus), 32'd0);
    check("rst_out_count", 32'(u_if.out_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 9; t++) begin
      send_group(tbl[t].op, int'(tbl[t].n), tbl[t].d, 1'b1);
      check($sformatf("tbl%0d_latency", t), 32'(u_if.out_valid), 32'd1);
      get_result($sformatf("tbl%0d", t), tbl[t].exp_bus, tbl[t].exp_cnt, t % 2);
    end

    // Backpressure: result held, in_ready low, stray operand refused.
    send_group(3'b000, 2, {4'b0000, 4'b1010, 4'b1100}, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        u_if.in_valid = 1'b1; u_if.in_bus = 4'b1111; u_if.in_last = 1'b1; u_if.op = 3'b001;
      end
      if (i == 3) begin
        u_if.in_valid = 1'b0; u_if.in_last = 1'b0;
      end
      check("bp_bus", 32'(u_if.out_bus), 32'b1000);
      check("bp_in_ready", 32'(u_if.in_ready), 32'd0);
      tick();
    end
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    check("bp_ready_after", 32'(u_if.in_ready), 32'd1);
    check("bp_valid_after", 32'(u_if.out_valid), 32'd0);
    send_group(3'b110, 1, {8'h00, 4'b0011}, 1'b1);
    get_result("bp_next", 4'b0011, 2'd1, 0);

    // Overrun: fourth operand waits for the handshake, then opens a new group.
    drive_beat(3'b001, 4'b0001, 1'b0);
    drive_beat(3'b001, 4'b0010, 1'b0);
    drive_beat(3'b001, 4'b0100, 1'b0);
    u_if.in_bus = 4'b1000; u_if.in_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("ovr_valid", 32'(u_if.out_valid), 32'd1);
      check("ovr_in_ready", 32'(u_if.in_ready), 32'd0);
      tick();
    end
    check("ovr_bus", 32'(u_if.out_bus), 32'b0111);
    check("ovr_cnt", 32'(u_if.out_count), 32'd3);
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    tick();
    check("ovr_new_grp_valid", 32'(u_if.out_valid), 32'd0);
    drive_beat(3'b010, 4'b0001, 1'b1);
    u_if.in_valid = 1'b0; u_if.in_last = 1'b0;
    get_result("ovr_grp2", 4'b1001, 2'd2, 1);

    // Reset mid-group discards the partial fold.
    drive_beat(3'b001, 4'b1111, 1'b0);
    drive_beat(3'b001, 4'b1111, 1'b0);
    u_if.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("mrst_out_bus", 32'(u_if.out_bus), 32'd0);
    check("mrst_out_count", 32'(u_if.out_count), 32'd0);
    check("mrst_in_ready", 32'(u_if.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    send_group(3'b010, 2, {4'b0000, 4'b0010, 4'b0001}, 1'b1);
    get_result("mrst_next", 4'b0011, 2'd2, 0);

    // Reset in DONE drops the pending result.
    send_group(3'b001, 1, {8'h00, 4'b1110}, 1'b1);
    check("drst_pre_valid", 32'(u_if.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("drst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("drst_in_ready", 32'(u_if.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    for (int g = 0; g < 40; g++) begin
      rop   = 3'($urandom_range(0, 7));
      rn    = $urandom_range(1, NB);
      rd    = 12'($urandom);
      rlast = (rn < NB) ? 1'b1 : 1'($urandom_range(0, 1));
      send_group(rop, rn, rd, rlast);
      get_result($sformatf("rnd%0d", g), model(rop, rn, rd), 2'(rn), $urandom_range(0, 3));
      for (int i = 0; i < $urandom_range(0, 2); i++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
